dec_sched: RTL
==============

DEC_SCHED -- requirements
Module: dec_sched

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, which sets the counter, load and decrementer data width.
REQ-002 Clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 Rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-004 ld_valid  input  1  load request.
REQ-005 ld_ch  input  2  target channel (0..3) for the load.
REQ-006 ld_val  input  DATAWIDTH  start count for the load.
REQ-007 ld_ready  output  1  load accepted on this edge when high with ld_valid.
REQ-008 halt  input  1  freeze arbitration and decrementing when high.
REQ-009 dec_a  output  DATAWIDTH  operand to the shared external DEC unit.
REQ-010 dec_d  input  DATAWIDTH  DEC result; the result equals dec_a-1, combinational.
REQ-011 gnt_valid  output  1  a channel owns the decrementer this cycle.
REQ-012 gnt_ch  output  2  granted channel index; 0 when gnt_valid=0.
REQ-013 active  output  4  per-channel armed flags.
REQ-014 done  output  4  per-channel one-cycle completion pulses, registered.

Function
REQ-015 The block SHALL hold four channels, each with a DATAWIDTH-bit count register and a two-state FSM: IDLE (active=0) or ARMED (active=1).
REQ-016 Arbitration SHALL be round-robin: when halt=0 and any channel is ARMED, grant the first ARMED channel searching ptr, ptr+1, ... mod 4. gnt_valid, gnt_ch and dec_a SHALL be combinational from registers.
REQ-017 On a granted edge, the block SHALL write count[gnt_ch] <= dec_d and set ptr <= gnt_ch+1 mod 4. One decrement SHALL occur per cycle in total.
REQ-018 If dec_d==0 on a granted edge, the channel SHALL go ARMED->IDLE, and done[gnt_ch] SHALL be high for exactly the following cycle.
REQ-019 If no channel is granted (none ARMED or halt=1), dec_a SHALL be 0, gnt_valid SHALL be 0, and ptr and counts SHALL hold.
REQ-020 ld_ready SHALL equal NOT(gnt_valid AND gnt_ch==ld_ch). A load SHALL never collide with the decrement of the same channel.
REQ-021 An accepted load with ld_val!=0 SHALL set count=ld_val and the channel to ARMED, overriding any count in progress (restart).
REQ-022 An accepted load with ld_val==0 SHALL leave the channel IDLE with count=0 and pulse done[ld_ch] in the next cycle.
REQ-023 A load and a completion on different channels in the same edge SHALL both take effect; done may have multiple bits set.
REQ-024 Latency: with a single ARMED channel, halt=0, and ld_val=N accepted on edge t0, done SHALL be high in the cycle after edge t0+N.
REQ-025 Loads SHALL be accepted while halt=1 (ld_ready=1 since gnt_valid=0).

Reset
REQ-026 While Rst=0, the block SHALL immediately clear all counts, active=0, done=0, and ptr=0; gnt_valid=0, gnt_ch=0 and dec_a=0 follow.
REQ-027 Reset asserted mid-count SHALL abort all channels with no done pulse; after release the first grant SHALL be to the lowest ARMED channel.

Configuration
REQ-028 Macro DEC_SCHED_RELOAD_EN SHALL select auto-reload behaviour.
- When defined: each channel keeps a reload register written by every accepted load. On reaching 0, the channel pulses done, sets count=reload, and stays ARMED (periodic); a load of 0 sets IDLE.
- When undefined: one-shot behaviour per REQ-018, and no reload registers exist.

Verification
REQ-029 Load ch0=3 only, halt=0 -> dec_a 3,2,1 on consecutive cycles; done=0001 in the cycle after the third grant; active[0] falls.
REQ-030 Load ch0=2 and ch2=2 on consecutive cycles -> grants alternate 0,2,0,2; done[0] pulses, then done[2] one cycle later.
REQ-031 ch1 ARMED and granted, ld_valid with ld_ch=1 -> ld_ready=0 that cycle; ld_ch=3 in the same cycle -> ld_ready=1 and the load is taken.
REQ-032 Load ch3=0 -> done=1000 next cycle, active[3] stays 0, gnt_valid stays 0.
REQ-033 ch0=5 running, halt=1 for 4 cycles -> count frozen, gnt_valid=0; resume gives done after 5 total grants. Rst=0 mid-count -> all outputs 0 immediately, no done.
REQ-034 With DEC_SCHED_RELOAD_EN, load ch0=2 -> done[0] pulses every 2 cycles indefinitely; load ch0=0 -> stops, and one done pulse follows.

Source files
------------

// File: rtl/dec_sched.sv
// Four-channel countdown scheduler sharing one external decrementer with round-robin arbitration.
// Define DEC_SCHED_RELOAD_EN for periodic auto-reload channels; leave it undefined for one-shot channels.
module dec_sched #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ld_valid,
   input  logic [1:0]           ld_ch,
   input  logic [DATAWIDTH-1:0] ld_val,
   output logic                 ld_ready,
   input  logic                 halt,
   output logic [DATAWIDTH-1:0] dec_a,
   input  logic [DATAWIDTH-1:0] dec_d,
   output logic                 gnt_valid,
   output logic [1:0]           gnt_ch,
   output logic [3:0]           active,
   output logic [3:0]           done
);

   typedef enum logic {IDLE, ARMED} ch_state_t;

   ch_state_t            state [4];
   logic [DATAWIDTH-1:0] count [4];
   logic [1:0]           ptr;
`ifdef DEC_SCHED_RELOAD_EN
   logic [DATAWIDTH-1:0] reload [4];
`endif

   // Round-robin search starting at ptr; the first ARMED channel found wins.
   always_comb begin : arb
      logic [1:0] idx;
      // NOTE: every output gets a default before the search so no latch is inferred.
      gnt_valid = 1'b0;
      gnt_ch    = 2'd0;
      idx       = 2'd0;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!halt && !gnt_valid && state[idx] == ARMED) begin
            gnt_valid = 1'b1;
            gnt_ch    = idx;
         end
      end
   end

   always_comb begin
      dec_a = gnt_valid ? count[gnt_ch] : '0;
      for (int i = 0; i < 4; i++) active[i] = (state[i] == ARMED);
   end

   // A load may never hit the channel that is being decremented this edge.
   assign ld_ready = !(gnt_valid && gnt_ch == ld_ch);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the per-channel arrays are small flop banks, so they are cleared in reset like any other state.
         for (int i = 0; i < 4; i++) begin
            count[i] <= '0;
            state[i] <= IDLE;
`ifdef DEC_SCHED_RELOAD_EN
            reload[i] <= '0;
`endif
         end
         ptr  <= 2'd0;
         done <= 4'd0;
      end else begin
         // NOTE: non-blocking assignments let the grant and load updates below coexist on one edge.
         done <= 4'd0;
         if (gnt_valid) begin
            count[gnt_ch] <= dec_d;
            ptr           <= gnt_ch + 2'd1;
            if (dec_d == '0) begin
               done[gnt_ch] <= 1'b1;
`ifdef DEC_SCHED_RELOAD_EN
               count[gnt_ch] <= reload[gnt_ch];
`else
               state[gnt_ch] <= IDLE;
`endif
            end
         end
         if (ld_valid && ld_ready) begin
`ifdef DEC_SCHED_RELOAD_EN
            reload[ld_ch] <= ld_val;
`endif
            count[ld_ch] <= ld_val;
            if (ld_val != '0) begin
               state[ld_ch] <= ARMED;
            end else begin
               state[ld_ch] <= IDLE;
               done[ld_ch]  <= 1'b1;
            end
         end
      end
   end

endmodule
